// File: rtl/arb_somador_ncl_pkg.sv
// -----------------------------------------------------------------------------
// arb_somador_ncl_pkg
// Shared definitions for the two-requester arbiter in front of an NCL
// (dual-rail, 4-phase) 4-bit adder stage.
//   - state_t           : controller FSM states
//   - NCL_NULL          : all-rails-low spacer word
//   - DR_ZERO / DR_ONE  : legal dual-rail pair codes ({true,false} rails)
//   - dr_encode_bit/4   : binary -> dual-rail
//   - dr_decode4        : dual-rail -> binary plus validity flag
// Rail mapping: bit i uses rails [2i+1] (true) and [2i] (false).
// -----------------------------------------------------------------------------
package arb_somador_ncl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_NULL_WAIT,
    ST_RECOVER,
    ST_RESP
  } state_t;

  localparam logic [7:0] NCL_NULL = 8'h00;
  localparam logic [1:0] DR_ZERO  = 2'b01;
  localparam logic [1:0] DR_ONE   = 2'b10;

  // Cycles the stage reset is held low during recovery.
  localparam int RECOVER_CYC = 2;

  typedef struct packed {
    logic       valid;
    logic [3:0] value;
  } dr_word_t;

  function automatic logic [1:0] dr_encode_bit(input logic b);
    return b ? DR_ONE : DR_ZERO;
  endfunction

  function automatic logic [7:0] dr_encode4(input logic [3:0] v);
    logic [7:0] rails;
    rails = NCL_NULL;
    for (int i = 0; i < 4; i++) begin
      rails[2*i +: 2] = dr_encode_bit(v[i]);
    end
    return rails;
  endfunction

  // A word with any NULL (00) or illegal (11) pair is invalid and decodes to 0.
  function automatic dr_word_t dr_decode4(input logic [7:0] rails);
    dr_word_t w;
    w.valid = 1'b1;
    w.value = 4'h0;
    for (int i = 0; i < 4; i++) begin
      case (rails[2*i +: 2])
        DR_ZERO: w.value[i] = 1'b0;
        DR_ONE:  w.value[i] = 1'b1;
        default: w.valid    = 1'b0;
      endcase
    end
    if (!w.valid) begin
      w.value = 4'h0;
    end
    return w;
  endfunction

endpackage

// File: rtl/arb_somador_ncl_if.sv
// -----------------------------------------------------------------------------
// arb_somador_ncl_if
// Bundles every non-clock signal of arb_somador_ncl.
//   requester side : req[1:0], a0/b0/a1/b1[3:0], cin[1:0] -> done[1:0], res, err
//   stage side     : ncl_a/ncl_b[7:0], ncl_cin[1:0] -> ncl_soma[7:0]
//   stage handshake: stage_ack -> ack_next, stage_rst_n
// modport slave  : the arbiter's view
// modport master : the environment's view (requesters + NCL stage)
// -----------------------------------------------------------------------------
interface arb_somador_ncl_if;
  logic [1:0] req;
  logic [3:0] a0;
  logic [3:0] b0;
  logic [3:0] a1;
  logic [3:0] b1;
  logic [1:0] cin;
  logic [1:0] done;
  logic [3:0] res;
  logic       err;
  logic [7:0] ncl_a;
  logic [7:0] ncl_b;
  logic [1:0] ncl_cin;
  logic [7:0] ncl_soma;
  logic       stage_ack;
  logic       ack_next;
  logic       stage_rst_n;

  modport slave (
    input  req, a0, b0, a1, b1, cin, ncl_soma, stage_ack,
    output done, res, err, ncl_a, ncl_b, ncl_cin, ack_next, stage_rst_n
  );

  modport master (
    output req, a0, b0, a1, b1, cin, ncl_soma, stage_ack,
    input  done, res, err, ncl_a, ncl_b, ncl_cin, ack_next, stage_rst_n
  );
endinterface

// File: rtl/arb_somador_ncl_sync.sv
// -----------------------------------------------------------------------------
// sincronizador_2ff
// Flop-chain synchronizer for a single asynchronous level.
//   clk  : destination clock
//   rst  : asynchronous active-high reset, clears every stage
//   d_i  : asynchronous input
//   q_o  : synchronized output, DEPTH cycles of latency
// -----------------------------------------------------------------------------
module sincronizador_2ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge neighbour; the async reset sits in the sensitivity list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/arb_somador_ncl.sv
// -----------------------------------------------------------------------------
// arb_somador_ncl
// Round-robin arbiter for two requesters sharing one NCL 4-bit adder stage.
// The grantee's operands are dual-rail encoded and driven to the stage; the
// registered dual-rail sum is captured once the (synchronized) stage ack is
// high, then the stage is returned to NULL and the result handed back.
// A per-phase timeout drops into RECOVER, which pulses the stage reset.
//   clk, rst          : clock, async active-high reset
//   bus.req/a*/b*/cin : requester inputs
//   bus.done/res/err  : per-requester completion, sum, error flag
//   bus.ncl_*         : dual-rail stage operands / registered sum
//   bus.stage_ack     : async stage acknowledge (synchronized internally)
//   bus.ack_next      : consumer acknowledge back to the stage
//   bus.stage_rst_n   : active-low stage reset
// -----------------------------------------------------------------------------
module arb_somador_ncl
  import arb_somador_ncl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  arb_somador_ncl_if.slave bus
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;     // requester currently being served
  logic             prio_q, prio_d;   // requester that wins a tie
  logic [7:0]       ncl_a_q, ncl_a_d;
  logic [7:0]       ncl_b_q, ncl_b_d;
  logic [1:0]       ncl_cin_q, ncl_cin_d;
  logic             ack_next_q, ack_next_d;
  logic             stage_rst_n_q, stage_rst_n_d;
  logic [1:0]       done_q, done_d;
  logic [3:0]       res_q, res_d;
  logic             err_q, err_d;
  logic [3:0]       sum_q, sum_d;     // sum captured from the stage
  logic             sum_err_q, sum_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;     // phase timeout / recovery counter

  logic     ack_s;
  logic     grant_valid;
  logic     grant_idx;
  logic     phase_expired;
  logic     recover_last;
  dr_word_t soma_dec;

  sincronizador_2ff #(
    .DEPTH (SYNC_STAGES)
  ) u_sync_ack (
    .clk (clk),
    .rst (rst),
    .d_i (bus.stage_ack),
    .q_o (ack_s)
  );

  // Priority requester wins if it asks; otherwise whichever one is asking.
  assign grant_valid   = |bus.req;
  assign grant_idx     = bus.req[prio_q] ? prio_q : ~prio_q;
  assign phase_expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign recover_last  = (cnt_q == CNT_W'(RECOVER_CYC - 1));
  assign soma_dec      = dr_decode4(bus.ncl_soma);

  // ---------------------------------------------------------------------------
  // State / datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      gnt_q         <= 1'b0;
      prio_q        <= 1'b0;
      ncl_a_q       <= NCL_NULL;
      ncl_b_q       <= NCL_NULL;
      ncl_cin_q     <= 2'b00;
      ack_next_q    <= 1'b0;
      stage_rst_n_q <= 1'b0;
      done_q        <= 2'b00;
      res_q         <= 4'h0;
      err_q         <= 1'b0;
      sum_q         <= 4'h0;
      sum_err_q     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      prio_q        <= prio_d;
      ncl_a_q       <= ncl_a_d;
      ncl_b_q       <= ncl_b_d;
      ncl_cin_q     <= ncl_cin_d;
      ack_next_q    <= ack_next_d;
      stage_rst_n_q <= stage_rst_n_d;
      done_q        <= done_d;
      res_q         <= res_d;
      err_q         <= err_d;
      sum_q         <= sum_d;
      sum_err_q     <= sum_err_d;
      cnt_q         <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assigning a default before the case keeps this combinational;
    // a path that leaves state_d unassigned would infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (ack_s)              state_d = ST_NULL_WAIT;
        else if (phase_expired) state_d = ST_RECOVER;
      end
      ST_NULL_WAIT: begin
        if (!ack_s)             state_d = ST_RESP;
        else if (phase_expired) state_d = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (recover_last) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (!bus.req[gnt_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered-output / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_d         = gnt_q;
    prio_d        = prio_q;
    ncl_a_d       = ncl_a_q;
    ncl_b_d       = ncl_b_q;
    ncl_cin_d     = ncl_cin_q;
    ack_next_d    = ack_next_q;
    stage_rst_n_d = stage_rst_n_q;
    done_d        = done_q;
    res_d         = res_q;
    err_d         = err_q;
    sum_d         = sum_q;
    sum_err_d     = sum_err_q;
    cnt_d         = cnt_q;

    case (state_q)
      ST_IDLE: begin
        // Leaving reset or recovery: release the stage.
        stage_rst_n_d = 1'b1;
        if (grant_valid) begin
          // Operands are frozen here; later requester changes are ignored.
          gnt_d     = grant_idx;
          ncl_a_d   = dr_encode4(grant_idx ? bus.a1 : bus.a0);
          ncl_b_d   = dr_encode4(grant_idx ? bus.b1 : bus.b0);
          ncl_cin_d = dr_encode_bit(bus.cin[grant_idx]);
          cnt_d     = '0;
        end
      end

      ST_DATA: begin
        if (ack_s) begin
          // Stage register is stable once the synchronized ack is high.
          sum_d      = soma_dec.value;
          sum_err_d  = ~soma_dec.valid;
          ncl_a_d    = NCL_NULL;
          ncl_b_d    = NCL_NULL;
          ncl_cin_d  = 2'b00;
          ack_next_d = 1'b1;
          cnt_d      = '0;
        end else if (phase_expired) begin
          ncl_a_d       = NCL_NULL;
          ncl_b_d       = NCL_NULL;
          ncl_cin_d     = 2'b00;
          ack_next_d    = 1'b0;
          stage_rst_n_d = 1'b0;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_NULL_WAIT: begin
        if (!ack_s) begin
          ack_next_d = 1'b0;
          done_d     = gnt_q ? 2'b10 : 2'b01;
          res_d      = sum_q;
          err_d      = sum_err_q;
        end else if (phase_expired) begin
          ncl_a_d       = NCL_NULL;
          ncl_b_d       = NCL_NULL;
          ncl_cin_d     = 2'b00;
          ack_next_d    = 1'b0;
          stage_rst_n_d = 1'b0;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RECOVER: begin
        if (recover_last) begin
          stage_rst_n_d = 1'b1;
          done_d        = gnt_q ? 2'b10 : 2'b01;
          res_d         = 4'h0;
          err_d         = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (!bus.req[gnt_q]) begin
          done_d = 2'b00;
          prio_d = ~gnt_q;
        end
      end

      default: ;
    endcase
  end

  assign bus.ncl_a       = ncl_a_q;
  assign bus.ncl_b       = ncl_b_q;
  assign bus.ncl_cin     = ncl_cin_q;
  assign bus.ack_next    = ack_next_q;
  assign bus.stage_rst_n = stage_rst_n_q;
  assign bus.done        = done_q;
  assign bus.res         = res_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_arb_somador_ncl.sv
// -----------------------------------------------------------------------------
// tb_arb_somador_ncl
// Drives two requesters and a behavioural zero-delay NCL adder stage into
// arb_somador_ncl. Expected responses are queued when a request is issued and
// compared by an independent monitor whenever done rises.
// -----------------------------------------------------------------------------
module tb_arb_somador_ncl;

  localparam int MODE_OK      = 0;  // stage computes a correct sum
  localparam int MODE_CORRUPT = 1;  // stage returns pair 1:0 = 11
  localparam int MODE_DEAD    = 2;  // stage never acknowledges

  typedef struct {
    int         who;
    logic [3:0] res;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   stage_mode = MODE_OK;
  int   prio_m = 0;         // requester the model expects to win a tie
  exp_t exp_q[$];

  arb_somador_ncl_if bus ();

  arb_somador_ncl #(
    .TIMEOUT_CYC (64),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural NCL stage: output is the sum as soon as all inputs are DATA.
  // ---------------------------------------------------------------------------
  logic       stage_ack_m;
  logic [7:0] soma_m;

  always_comb begin : stage_model
    logic       complete;
    logic [3:0] av;
    logic [3:0] bv;
    logic [4:0] s;
    complete = bus.ncl_cin[1] | bus.ncl_cin[0];
    av = 4'h0;
    bv = 4'h0;
    for (int i = 0; i < 4; i++) begin
      complete = complete & (bus.ncl_a[2*i+1] | bus.ncl_a[2*i])
                          & (bus.ncl_b[2*i+1] | bus.ncl_b[2*i]);
      av[i] = bus.ncl_a[2*i+1];
      bv[i] = bus.ncl_b[2*i+1];
    end
    s = {1'b0, av} + {1'b0, bv} + {4'b0, bus.ncl_cin[1]};
    soma_m = 8'h00;
    if (complete) begin
      for (int i = 0; i < 4; i++) begin
        soma_m[2*i+1] = s[i];
        soma_m[2*i]   = ~s[i];
      end
      if (stage_mode == MODE_CORRUPT) soma_m[1:0] = 2'b11;
    end
    stage_ack_m = complete && (stage_mode != MODE_DEAD) && bus.stage_rst_n;
  end

  assign bus.stage_ack = stage_ack_m;
  assign bus.ncl_soma  = soma_m;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] tb_enc(input logic [3:0] v);
    logic [7:0] r;
    for (int i = 0; i < 4; i++) begin
      r[2*i+1] = v[i];
      r[2*i]   = ~v[i];
    end
    return r;
  endfunction

  task automatic set_ops(input int who, input logic [3:0] a, input logic [3:0] b, input logic c);
    if (who == 0) begin
      bus.a0 = a; bus.b0 = b; bus.cin[0] = c;
    end else begin
      bus.a1 = a; bus.b1 = b; bus.cin[1] = c;
    end
  endtask

  task automatic push_exp(input int who, input logic [3:0] a, input logic [3:0] b, input logic c);
    exp_t       e;
    logic [4:0] s;
    e.who = who;
    if (stage_mode == MODE_OK) begin
      s     = {1'b0, a} + {1'b0, b} + {4'b0, c};
      e.res = s[3:0];
      e.err = 1'b0;
    end else begin
      e.res = 4'h0;
      e.err = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  // Single requester: load operands, queue expectation, raise req.
  task automatic issue(input int who, input logic [3:0] a, input logic [3:0] b, input logic c);
    set_ops(who, a, b, c);
    push_exp(who, a, b, c);
    bus.req[who] = 1'b1;
    prio_m = 1 - who;
  endtask

  task automatic wait_done(input int who);
    int n = 0;
    while (!bus.done[who] && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'b0, bus.done[who]}, 1);
  endtask

  task automatic drop_req(input int who);
    int n = 0;
    bus.req[who] = 1'b0;
    while (bus.done[who] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("done_clear", {31'b0, bus.done[who]}, 0);
    check("done_clear_latency", n, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"},        {30'b0, bus.done}, 0);
    check({tag, "_res"},         {28'b0, bus.res}, 0);
    check({tag, "_err"},         {31'b0, bus.err}, 0);
    check({tag, "_ncl_a"},       {24'b0, bus.ncl_a}, 0);
    check({tag, "_ncl_b"},       {24'b0, bus.ncl_b}, 0);
    check({tag, "_ncl_cin"},     {30'b0, bus.ncl_cin}, 0);
    check({tag, "_ack_next"},    {31'b0, bus.ack_next}, 0);
    check({tag, "_stage_rst_n"}, {31'b0, bus.stage_rst_n}, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compare every rising done against the scoreboard head.
  // ---------------------------------------------------------------------------
  logic [1:0] done_prev;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (rst) begin
      done_prev = 2'b00;
    end else begin
      if (bus.done != 2'b00 && done_prev == 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {30'b0, bus.done}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_grantee", {30'b0, bus.done}, (mon_e.who == 0) ? 32'd1 : 32'd2);
          check("res", {28'b0, bus.res}, {28'b0, mon_e.res});
          check("err", {31'b0, bus.err}, {31'b0, mon_e.err});
        end
      end
      done_prev = bus.done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int         n;
    int         ack_first;
    int         low_cnt;
    int         first_low;
    int         ack_seen;
    int         first;
    int         second;
    int         who;
    logic [3:0] a, b, a_o, b_o;
    logic       c, c_o;

    rst = 1'b1;
    bus.req = 2'b00;
    set_ops(0, 4'h0, 4'h0, 1'b0);
    set_ops(1, 4'h0, 4'h0, 1'b0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    rst = 1'b0;
    #1 check("stage_rst_n_before_edge", {31'b0, bus.stage_rst_n}, 0);
    @(negedge clk);
    check("stage_rst_n_after_edge", {31'b0, bus.stage_rst_n}, 1);

    // Zero-delay latency, 3 + 5 + 0 = 8.
    issue(0, 4'h3, 4'h5, 1'b0);
    n = 0;
    ack_first = -1;
    while (!bus.done[0] && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("ncl_a_data", {24'b0, bus.ncl_a}, {24'b0, tb_enc(4'h3)});
        check("ncl_b_data", {24'b0, bus.ncl_b}, {24'b0, tb_enc(4'h5)});
        check("ncl_cin_data", {30'b0, bus.ncl_cin}, 32'h1);
      end
      if (ack_first < 0 && bus.ack_next) ack_first = n - 1;
    end
    check("ack_next_edge", ack_first, 3);
    check("done_edge", n - 1, 6);
    drop_req(0);

    // Wrap: F + 1 + 1 = 0x11 -> 1.
    issue(0, 4'hF, 4'h1, 1'b1);
    wait_done(0);
    drop_req(0);

    // Serve requester 1 so requester 0 is preferred for the tie test.
    issue(1, 4'h9, 4'h4, 1'b1);
    wait_done(1);
    drop_req(1);

    // Simultaneous requests, twice: expected grants 0,1,0,1.
    for (int round = 0; round < 2; round++) begin
      a = 4'($urandom); b = 4'($urandom); c = 1'($urandom);
      a_o = 4'($urandom); b_o = 4'($urandom); c_o = 1'($urandom);
      set_ops(0, a, b, c);
      set_ops(1, a_o, b_o, c_o);
      first  = prio_m;
      second = 1 - prio_m;
      if (first == 0) begin
        push_exp(0, a, b, c);
        push_exp(1, a_o, b_o, c_o);
      end else begin
        push_exp(1, a_o, b_o, c_o);
        push_exp(0, a, b, c);
      end
      bus.req = 2'b11;
      wait_done(first);
      drop_req(first);
      wait_done(second);
      drop_req(second);
      prio_m = first;
    end

    // Illegal pair from the stage.
    stage_mode = MODE_CORRUPT;
    issue(0, 4'h6, 4'h2, 1'b0);
    wait_done(0);
    drop_req(0);
    stage_mode = MODE_OK;

    // Dead stage: timeout in DATA, two-cycle stage reset, error result.
    stage_mode = MODE_DEAD;
    issue(0, 4'h1, 4'h2, 1'b0);
    n = 0; low_cnt = 0; first_low = -1; ack_seen = 0;
    while (!bus.done[0] && n < 200) begin
      @(negedge clk);
      n++;
      if (!bus.stage_rst_n) begin
        low_cnt++;
        if (first_low < 0) first_low = n - 1;
      end
      if (bus.ack_next) ack_seen = 1;
    end
    check("recover_edge", first_low, 64);
    check("stage_rst_low_cycles", low_cnt, 2);
    check("timeout_done_edge", n - 1, 66);
    check("timeout_no_ack_next", ack_seen, 0);
    drop_req(0);
    stage_mode = MODE_OK;

    // Reset while waiting for NULL: transaction abandoned.
    issue(0, 4'hA, 4'h7, 1'b1);
    n = 0;
    while (!bus.ack_next && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("null_wait_reached", {31'b0, bus.ack_next}, 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midreset");
    exp_q.delete();
    bus.req = 2'b00;
    prio_m = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("no_done_after_reset", {30'b0, bus.done}, 0);
    issue(0, 4'h2, 4'h2, 1'b0);
    wait_done(0);
    drop_req(0);

    // Randomized single-requester traffic with operand changes after grant.
    for (int t = 0; t < 16; t++) begin
      who = int'($urandom_range(0, 1));
      a = 4'($urandom); b = 4'($urandom); c = 1'($urandom);
      issue(who, a, b, c);
      @(negedge clk);
      set_ops(who, 4'($urandom), 4'($urandom), 1'($urandom));
      wait_done(who);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      drop_req(who);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arb_somador_ncl.md
ARB_SOMADOR_NCL -- requirements
Module: arb_somador_ncl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 64, meaning the maximum number of cycles spent waiting on one stage-ack phase before recovery.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the flop depth of the stage_ack synchronizer.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: `clk  in  1  sole clock`; `rst  in  1  async active-high reset`.
REQ-004 Requester ports SHALL be: `req  in  2  per-requester 4-phase request`; `a0, b0, a1, b1  in  4  binary operands`; `cin  in  2  per-requester carry-in`.
REQ-005 Result ports SHALL be: `done  out  2  per-requester completion`; `res  out  4  binary sum`; `err  out  1  result invalid or timed out`.
REQ-006 Stage-side ports SHALL be: `ncl_a, ncl_b  out  8  dual-rail operands`; `ncl_cin  out  2  dual-rail carry`; `ncl_soma  in  8  dual-rail registered sum`.
REQ-007 Stage handshake ports SHALL be: `stage_ack  in  1  async stage acknowledge`; `ack_next  out  1  consumer acknowledge to stage`; `stage_rst_n  out  1  active-low stage reset`.

Function
REQ-008 Dual-rail encoding SHALL be: bit i maps to rails [2i+1] (true) and [2i] (false); NULL is all zeros; 01 means 0; 10 means 1; 11 is illegal.
REQ-009 The FSM SHALL have the states IDLE, DATA, NULL_WAIT, RECOVER and RESP.
REQ-010 In IDLE with any req high, the block SHALL grant round-robin (the last-granted requester gets lowest priority; requester 0 wins first after reset) and drive the encoded operands plus cin of the grantee at the next edge, entering DATA.
REQ-011 stage_ack SHALL be used only through the SYNC_STAGES-flop synchronizer (ack_s); ncl_soma SHALL be sampled only on the edge where ack_s is seen high, since the stage register is then stable.
REQ-012 On DATA with ack_s=1, at the same edge the block SHALL capture ncl_soma, drive NULL on all ncl_* outputs, set ack_next=1, and enter NULL_WAIT.
REQ-013 On NULL_WAIT with ack_s=0, at the same edge the block SHALL clear ack_next, set done[g]=1, present res/err, and enter RESP.
REQ-014 With a zero-delay stage, a req sampled at edge E0 SHALL cause DATA to be driven after E0, ack_next to rise after E3, and done to rise after E6.
REQ-015 The captured sum SHALL be decoded per bit: if any pair is 00 or 11, the block SHALL set res=0 and err=1; otherwise it SHALL set err=0.
REQ-016 In RESP, done, res and err SHALL hold until req[g] is sampled low; then done SHALL clear at the next edge, the round-robin pointer SHALL update, and the FSM SHALL return to IDLE.
REQ-017 Requester operands SHALL be registered at grant; later changes while req is held SHALL be ignored.
REQ-018 A cycle counter SHALL clear on entry to DATA and to NULL_WAIT; reaching TIMEOUT_CYC in either state SHALL cause entry to RECOVER.
REQ-019 RECOVER SHALL drive NULL, set ack_next=0, hold stage_rst_n=0 for exactly 2 cycles, then enter RESP with err=1 and res=0.
REQ-020 A req rising for the non-granted requester mid-transaction SHALL wait; it SHALL never abort the current transaction.
REQ-021 Both req bits rising in the same cycle SHALL be resolved by the round-robin pointer alone.

Reset
REQ-022 While rst=1, all state SHALL clear asynchronously: done=0, res=0, err=0, ncl_*=NULL, ack_next=0, stage_rst_n=0, FSM=IDLE, pointer=requester 0, synchronizer flops=0.
REQ-023 stage_rst_n SHALL rise at the first clk edge after rst falls; a grant SHALL be possible no earlier than that edge.
REQ-024 Reset asserted mid-transaction SHALL abandon that transaction with no done pulse.

Structure
REQ-025 The shared package SHALL hold the state enum, the NULL constant, the DR_ZERO/DR_ONE pair constants, and the encode/decode-with-validity functions.
REQ-026 The synchronizer SHALL be the single sub-module sincronizador_2ff, parameterized by depth; everything else SHALL be in one module.

Verification
REQ-027 The bench SHALL cover: req0 with a0=4'h3, b0=4'h5, cin=0 against a zero-delay stage model -> ack_next rises after E3, done[0] after E6, res=4'h8, err=0.
REQ-028 The bench SHALL cover: req0 and req1 raised together, then re-raised each time -> grants alternate 0,1,0,1 with results correct per requester.
REQ-029 The bench SHALL cover: stage model returning pair bits 1:0 = 11 -> done with err=1, res=0.
REQ-030 The bench SHALL cover: stage_ack held low -> RECOVER after 64 cycles in DATA, stage_rst_n low exactly 2 cycles, then done with err=1.
REQ-031 The bench SHALL cover: a0=4'hF, b0=4'h1, cin=1 -> res=4'h1 (wrap, no carry-out).
REQ-032 The bench SHALL cover: rst pulsed while in NULL_WAIT -> all outputs at reset values immediately, no done, and the next req served normally.
